// File: rtl/phase_inc_est_pkg.sv
// phase_inc_est_pkg: shared phase/DSP types, FSM state and min/max helpers.
package phase_inc_est_pkg;
  localparam int PHASE_W = 32;
  localparam int SUM_W = 34;
  typedef logic signed [PHASE_W-1:0] step_t;
  typedef logic signed [SUM_W-1:0] sum_t;
  typedef enum logic {PRIME, ACCUM} state_t;
  localparam step_t STEP_MAX = {1'b0, {(PHASE_W-1){1'b1}}};
  localparam step_t STEP_MIN = {1'b1, {(PHASE_W-1){1'b0}}};
  function automatic step_t smin(step_t a, step_t b);
    return a < b ? a : b;
  endfunction
  function automatic step_t smax(step_t a, step_t b);
    return a > b ? a : b;
  endfunction
endpackage

// File: rtl/phase_inc_est_if.sv
// phase_inc_est_if: four-sample phase beat in, averaged increment estimate out.
interface phase_inc_est_if;
  logic valid_i;
  logic clear_i;
  logic [phase_inc_est_pkg::PHASE_W-1:0] phase0_i, phase1_i, phase2_i, phase3_i;
  logic [phase_inc_est_pkg::PHASE_W-1:0] p_inc_o;
  logic valid_o;
  logic lock_o;
  modport master(output valid_i, clear_i, phase0_i, phase1_i, phase2_i, phase3_i,
                 input p_inc_o, valid_o, lock_o);
  modport slave(input valid_i, clear_i, phase0_i, phase1_i, phase2_i, phase3_i,
                output p_inc_o, valid_o, lock_o);
endinterface

// File: rtl/phase_step4.sv
// phase_step4: registers the four per-sample phase steps of a beat and reduces them to sum/min/max.
module phase_step4 import phase_inc_est_pkg::*; (
  input  logic clk_i,
  input  logic rst_n_i,
  input  logic en,
  input  logic [PHASE_W-1:0] prev3,
  input  logic [PHASE_W-1:0] phase0,
  input  logic [PHASE_W-1:0] phase1,
  input  logic [PHASE_W-1:0] phase2,
  input  logic [PHASE_W-1:0] phase3,
  output sum_t sum,
  output step_t bmin,
  output step_t bmax
);
  step_t d0, d1, d2, d3;
  // modular subtraction makes phase wrap-around transparent
  always_ff @(posedge clk_i or negedge rst_n_i)
    if (!rst_n_i) begin
      d0 <= '0;
      d1 <= '0;
      d2 <= '0;
      d3 <= '0;
    end else if (en) begin
      d0 <= step_t'(phase0 - prev3);
      d1 <= step_t'(phase1 - phase0);
      d2 <= step_t'(phase2 - phase1);
      d3 <= step_t'(phase3 - phase2);
    end
  assign sum = sum_t'(d0) + sum_t'(d1) + sum_t'(d2) + sum_t'(d3);
  assign bmin = smin(smin(d0, d1), smin(d2, d3));
  assign bmax = smax(smax(d0, d1), smax(d2, d3));
endmodule

// File: rtl/phase_inc_est.sv
// phase_inc_est: averages per-sample phase steps over 2^AVG_LOG2 beats into an NCO increment estimate.
module phase_inc_est import phase_inc_est_pkg::*; #(
  parameter int AVG_LOG2 = 4,
  parameter logic [PHASE_W-1:0] TOL = 32'h0001_0000
) (
  input logic clk_i,
  input logic rst_n_i,
  phase_inc_est_if.slave bus
);
  localparam int AW = SUM_W + AVG_LOG2;
  localparam int CW = AVG_LOG2 > 0 ? AVG_LOG2 : 1;
  localparam logic [CW-1:0] LAST = CW'((1 << AVG_LOG2) - 1);
  state_t state;
  logic [CW-1:0] cnt;
  logic [PHASE_W-1:0] prev3;
  logic accept, v1, last1, fv, vout, lock;
  logic signed [AW-1:0] acc, acc_n, fa;
  step_t mn, mx, mn_n, mx_n, fmn, fmx, bmin, bmax;
  sum_t sum;
  logic [PHASE_W:0] spread;
  logic [PHASE_W-1:0] p_inc;
  assign accept = bus.valid_i && !bus.clear_i;
  phase_step4 u_step (
    .clk_i,
    .rst_n_i,
    .en(accept),
    .prev3,
    .phase0(bus.phase0_i),
    .phase1(bus.phase1_i),
    .phase2(bus.phase2_i),
    .phase3(bus.phase3_i),
    .sum,
    .bmin,
    .bmax
  );
  // S1: priming FSM and beat counter; steps are registered inside phase_step4
  always_ff @(posedge clk_i or negedge rst_n_i)
    if (!rst_n_i) begin
      state <= PRIME;
      cnt <= '0;
      prev3 <= '0;
      v1 <= 1'b0;
      last1 <= 1'b0;
    end else if (bus.clear_i) begin
      state <= PRIME;
      cnt <= '0;
      v1 <= 1'b0;
      last1 <= 1'b0;
    end else begin
      v1 <= bus.valid_i && state == ACCUM;
      last1 <= bus.valid_i && state == ACCUM && cnt == LAST;
      if (bus.valid_i) begin
        prev3 <= bus.phase3_i;
        state <= ACCUM;
        if (state == ACCUM) cnt <= cnt == LAST ? '0 : cnt + 1'b1;
      end
    end
  always_comb begin
    acc_n = acc + AW'(sum);
    mn_n = smin(mn, bmin);
    mx_n = smax(mx, bmax);
  end
  // S2: the final beat of a window lands in the f* registers so the next window starts clean
  always_ff @(posedge clk_i or negedge rst_n_i)
    if (!rst_n_i) begin
      acc <= '0;
      mn <= STEP_MAX;
      mx <= STEP_MIN;
      fa <= '0;
      fmn <= '0;
      fmx <= '0;
      fv <= 1'b0;
    end else if (bus.clear_i) begin
      acc <= '0;
      mn <= STEP_MAX;
      mx <= STEP_MIN;
      fv <= 1'b0;
    end else begin
      fv <= v1 && last1;
      if (v1 && last1) begin
        acc <= '0;
        mn <= STEP_MAX;
        mx <= STEP_MIN;
        fa <= acc_n;
        fmn <= mn_n;
        fmx <= mx_n;
      end else if (v1) begin
        acc <= acc_n;
        mn <= mn_n;
        mx <= mx_n;
      end
    end
  assign spread = {fmx[PHASE_W-1], fmx} - {fmn[PHASE_W-1], fmn};
  // S3: divide by samples per window (arithmetic shift floors toward -inf)
  always_ff @(posedge clk_i or negedge rst_n_i)
    if (!rst_n_i) begin
      vout <= 1'b0;
      p_inc <= '0;
      lock <= 1'b0;
    end else if (bus.clear_i) begin
      vout <= 1'b0;
    end else begin
      vout <= fv;
      if (fv) begin
        p_inc <= PHASE_W'(fa >>> (AVG_LOG2 + 2));
        lock <= spread <= {1'b0, TOL};
      end
    end
  assign bus.p_inc_o = p_inc;
  assign bus.valid_o = vout;
  assign bus.lock_o = lock;
endmodule

// File: tb/tb_phase_inc_est.sv
// tb_phase_inc_est: random/directed phase streams scored against a window-average model.
module tb_phase_inc_est;
  localparam int AVG = 4;
  localparam int NB = 1 << AVG;
  localparam logic [31:0] TOL_A = 32'h0001_0000;
  localparam logic [31:0] TOL_B = 32'h0020_0000;
  typedef struct {
    logic [31:0] p;
    logic la;
    logic lb;
    longint due;
  } exp_t;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic valid = 1'b0;
  logic clear = 1'b0;
  logic [31:0] ph [4];
  logic [31:0] cur = '0;
  logic [31:0] prev = '0;
  bit primed = 0;
  int steps [$];
  exp_t sb [$];
  exp_t e_m;
  longint cyc = 0;
  int n_cmp = 0;
  int n_err = 0;

  phase_inc_est_if ifa ();
  phase_inc_est_if ifb ();
  assign ifa.valid_i = valid;
  assign ifa.clear_i = clear;
  assign ifa.phase0_i = ph[0];
  assign ifa.phase1_i = ph[1];
  assign ifa.phase2_i = ph[2];
  assign ifa.phase3_i = ph[3];
  assign ifb.valid_i = valid;
  assign ifb.clear_i = clear;
  assign ifb.phase0_i = ph[0];
  assign ifb.phase1_i = ph[1];
  assign ifb.phase2_i = ph[2];
  assign ifb.phase3_i = ph[3];

  phase_inc_est #(.AVG_LOG2(AVG), .TOL(TOL_A)) dut_a (.clk_i(clk), .rst_n_i(rst_n), .bus(ifa.slave));
  phase_inc_est #(.AVG_LOG2(AVG), .TOL(TOL_B)) dut_b (.clk_i(clk), .rst_n_i(rst_n), .bus(ifb.slave));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic void chk(string name, logic [63:0] act, logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endfunction

  // Reference: collect every step since priming; a full window is averaged with floor division.
  function automatic void model_beat(bit v, bit c);
    longint s, q, spread;
    int mn, mx;
    if (c) begin
      primed = 0;
      steps.delete();
    end else if (v) begin
      if (primed) begin
        steps.push_back(int'(ph[0] - prev));
        for (int k = 1; k < 4; k++) steps.push_back(int'(ph[k] - ph[k-1]));
      end
      primed = 1;
      prev = ph[3];
      if (steps.size() == 4 * NB) begin
        s = 0;
        mn = steps[0];
        mx = steps[0];
        foreach (steps[i]) begin
          s += steps[i];
          if (steps[i] < mn) mn = steps[i];
          if (steps[i] > mx) mx = steps[i];
        end
        q = s / (4 * NB);
        if (s % (4 * NB) != 0 && s < 0) q--;
        spread = longint'(mx) - longint'(mn);
        sb.push_back('{p: q[31:0], la: spread <= longint'(TOL_A), lb: spread <= longint'(TOL_B), due: cyc + 3});
        steps.delete();
      end
    end
  endfunction

  task automatic beat(input logic [31:0] s0, s1, s2, s3, input bit c = 0);
    @(negedge clk);
    ph[0] = cur + s0;
    ph[1] = ph[0] + s1;
    ph[2] = ph[1] + s2;
    ph[3] = ph[2] + s3;
    cur = ph[3];
    valid = 1'b1;
    clear = c;
    model_beat(1'b1, c);
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      valid = 1'b0;
      clear = 1'b0;
    end
  endtask

  task automatic nco(input logic [31:0] inc, input int n);
    repeat (n) beat(inc, inc, inc, inc);
  endtask

  always @(negedge clk) if (rst_n) begin
    if (ifa.valid_o) begin
      if (sb.size() == 0) chk("unexpected_valid_o", 1, 0);
      else begin
        e_m = sb.pop_front();
        chk("p_inc_a", ifa.p_inc_o, e_m.p);
        chk("p_inc_b", ifb.p_inc_o, e_m.p);
        chk("lock_a", ifa.lock_o, e_m.la);
        chk("lock_b", ifb.lock_o, e_m.lb);
        chk("valid_b", ifb.valid_o, 1);
        chk("latency", cyc, e_m.due);
      end
    end else if (ifb.valid_o) chk("valid_b_extra", 1, 0);
    else if (sb.size() > 0 && cyc > sb[0].due) begin
      chk("missing_valid_o", cyc, sb[0].due);
      void'(sb.pop_front());
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    for (int i = 0; i < 4; i++) ph[i] = '0;
    #12;
    chk("rst_p_inc", ifa.p_inc_o, 0);
    chk("rst_valid", ifa.valid_o, 0);
    chk("rst_lock", ifa.lock_o, 0);
    @(negedge clk);
    rst_n = 1'b1;
    cur = $urandom;
    nco(32'h0100_0000, 17 + 2 * NB);
    idle(4);
    cur = 32'h0000_0800;
    nco(32'hFFFF_FF00, 17 + 2 * NB);
    idle(4);
    repeat (1 + NB) beat(32'h0010_0000, 32'h0030_0000, 32'h0010_0000, 32'h0030_0000);
    idle(4);
    repeat (17 + 2 * NB) begin
      beat(32'h1234_5678, 32'h1234_5678, 32'h1234_5678, 32'h1234_5678);
      idle($urandom_range(0, 7));
    end
    idle(4);
    repeat (1 + 2 * NB) beat(32'h0800_0000 + $urandom_range(0, 32'h3_0000) - 32'h1_8000,
                             32'h0800_0000 + $urandom_range(0, 32'h3_0000) - 32'h1_8000,
                             32'h0800_0000 + $urandom_range(0, 32'h3_0000) - 32'h1_8000,
                             32'h0800_0000 + $urandom_range(0, 32'h3_0000) - 32'h1_8000);
    idle(4);
    nco(32'h0100_0000, 17 + 8);
    beat(32'h0100_0000, 32'h0100_0000, 32'h0100_0000, 32'h0100_0000, 1'b1);
    nco(32'h0100_0000, 17);
    idle(4);
    nco(32'h0100_0000, 17 + 5);
    idle(3);
    @(posedge clk);
    #2 rst_n = 1'b0;
    primed = 0;
    steps.delete();
    sb.delete();
    #1;
    chk("async_rst_p_inc", ifa.p_inc_o, 0);
    chk("async_rst_lock", ifa.lock_o, 0);
    chk("async_rst_valid", ifa.valid_o, 0);
    #1 rst_n = 1'b1;
    nco(32'h0100_0000, 17);
    idle(6);
    chk("sb_drained", sb.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/phase_inc_est.md
# phase_inc_est

Phase-increment estimator: the receive-side inverse of the 4-phase NCO phase generator. It accepts four parallel 32-bit phase samples per clock, for example the output of a phase detector/CORDIC on received IQ. It measures the per-sample phase step and averages it over a programmable window. Each window produces a registered 32-bit increment estimate in the same units as the NCO `p_inc`, plus a lock flag, so the estimate can be fed back to the NCO for frequency tracking.

## Interface
- `AVG_LOG2`, default 4: window length is 2^AVG_LOG2 input beats (4·2^AVG_LOG2 samples); legal range 0..8.
- `TOL`, default 32'h0001_0000: maximum allowed window spread (max−min sample step) for lock.
- `clk_i`  in  1  single clock; all logic on rising edge.
- `rst_n_i`  in  1  asynchronous, active-low reset.
- `valid_i`  in  1  phase beat valid; a beat is accepted on any edge with `valid_i`=1.
- `clear_i`  in  1  synchronous restart; discards the window in progress and re-primes.
- `phase0_i`..`phase3_i`  in  32 each  samples n..n+3, oldest in `phase0_i`.
- `p_inc_o`  out  32  averaged per-sample step, two's complement; reset 0.
- `valid_o`  out  1  one-cycle strobe when `p_inc_o`/`lock_o` update; reset 0.
- `lock_o`  out  1  last window spread ≤ `TOL`; reset 0.

## Operation
- Step per beat: d0=phase0−prev3, d1=phase1−phase0, d2=phase2−phase1, d3=phase3−phase2.
  - Each step is computed mod 2^32 and then interpreted as signed 32-bit. Wrap-around of the phase is therefore transparent.
  - `prev3` is the `phase3_i` of the previous accepted beat.
- FSM states:
  - PRIME: entered from reset and after `clear_i`. The first accepted beat only loads `prev3`; no steps are accumulated. Go to ACCUM.
  - ACCUM: each accepted beat adds d0+d1+d2+d3 (sign-extended to 34 bits) into an accumulator of 34+AVG_LOG2 bits. It also updates the running min and max of all four d values. A beat counter counts 0..2^AVG_LOG2−1.
  - DUMP: entered on the last beat of a window. Not a wait state; the pipeline issues the output and ACCUM continues with the next beat, with no beat lost.
- Window result:
  - `p_inc_o` = accumulator >>> (AVG_LOG2+2), an arithmetic shift that truncates toward −∞, keeping the low 32 bits.
  - `lock_o` = (max−min ≤ `TOL`), with the comparison done unsigned on the 33-bit difference.
  - The accumulator, counter, min and max re-initialise for the next window. `prev3` is kept, so consecutive windows are seamless.
- `valid_i`=0 beats are ignored. Counter and accumulator hold, and gaps of any length are allowed.
- `clear_i` has priority over `valid_i` in the same cycle. That beat is discarded and the FSM goes to PRIME.
  - Outputs hold their last values and `valid_o` stays 0.
  - A window result already in the pipeline is suppressed.
- Steps with magnitude ≥2^31 are aliased by design. The upstream design guarantees |step| < 2^31.

## Timing
- Pipeline stages:
  - S1: register d0..d3 and the valid bit.
  - S2: 4-way sum, min/max update, accumulate.
  - S3: shift/compare and output register.
- Latency: if the last beat of a window is sampled at edge k, then `valid_o`, `p_inc_o` and `lock_o` update at edge k+2. `valid_o` is high for exactly one cycle.
- Throughput: one beat per clock sustained. Each window produces one result every 2^AVG_LOG2 accepted beats.
- Reset asserted mid-window: all state and outputs go to 0 immediately and asynchronously. After deassertion the block restarts in PRIME.
- With AVG_LOG2=0 every beat after priming produces a result, and `valid_o` may be high on consecutive cycles.

## Structure
- A shared DSP package holds:
  - `PHASE_W`=32;
  - the signed step type (32 bits) and the sum type (34 bits);
  - the FSM state enum (PRIME, ACCUM) for reuse by a future loop filter.
- One sub-module, `phase_step4`, is natural. It takes `prev3` and phase0..3, and produces d0..d3 (S1 registers), the 34-bit sum, and the beat min/max.

## Test plan
- Drive with the NCO phase generator at p_inc=32'h0100_0000, AVG_LOG2=4, continuous valid. The first `valid_o` comes 17 beats + 2 cycles after the first beat, with `p_inc_o`=32'h0100_0000 and `lock_o`=1; repeats every 16 cycles.
- p_inc=32'hFFFF_FF00 (negative), with the phase wrapping through 0 repeatedly → `p_inc_o`=32'hFFFF_FF00, `lock_o`=1, and no glitch at the wrap.
- Alternate steps of 32'h0010_0000 and 32'h0030_0000, with TOL=32'h0001_0000 → `p_inc_o`=32'h0020_0000, `lock_o`=0. Repeat with TOL=32'h0020_0000 → `lock_o`=1.
- Random `valid_i` gaps of 0–7 cycles with p_inc=32'h1234_5678 → identical results, and exactly one `valid_o` per 16 accepted beats.
- Assert `clear_i` at beat 9 of a window → no `valid_o` for that window. The next result arrives 17 accepted beats after the clear and is correct.
- Pulse `rst_n_i` low for less than one cycle mid-window → outputs go to 0 immediately. After release the block re-primes and the first result is correct.
